// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: state encoding, protocol
// constants and keyboard command codes.
`default_nettype none

package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_e;

  localparam logic       PS2_ACK      = 1'b0;
  localparam logic [7:0] PS2_FALL_PAT = 8'b1111_0000;
  localparam logic [3:0] PS2_PAR_BIT  = 4'd8;
  localparam logic [3:0] PS2_STOP_BIT = 4'd9;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioner: 2-flop synchronizers for clock and data, plus a
// shift-register edge filter on the clock producing one-cycle fall/rise strobes.
`default_nettype none

module ps2_clk_filter
  import ps2_host_tx_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key_clk_i,
  input  logic key_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic fall_o,
  output logic rise_o
);

  // Older half of the window high, newer half low; newest sample sits at bit 0.
  localparam logic [FILTER_LEN-1:0] FALL_PAT = (FILTER_LEN == 8)
      ? FILTER_LEN'(PS2_FALL_PAT)
      : FILTER_LEN'({FILTER_LEN{1'b1}} << (FILTER_LEN / 2));

  logic [1:0]            clk_sync_q;
  logic [1:0]            data_sync_q;
  logic [FILTER_LEN-1:0] hist_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      hist_q      <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], key_clk_i};
      data_sync_q <= {data_sync_q[0], key_data_i};
      hist_q      <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
    end
  end

  assign clk_s_o  = clk_sync_q[1];
  assign data_s_o = data_sync_q[1];
  assign fall_o   = (hist_q == FALL_PAT);
  assign rise_o   = (hist_q == ~FALL_PAT);

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, ten device-clocked
// bits (data LSB first, odd parity, stop), ACK check and bus-idle wait.
`default_nettype none

module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       key_clk_i,
  input  logic       key_data_i,
  output logic       key_clk_low_o,
  output logic       key_data_low_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_s, data_s, fall, clk_rise_unused;

  state_e           state_q, state_d;
  logic [7:0]       sh_q, sh_d;
  logic             par_q, par_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             clk_low_q, clk_low_d;
  logic             data_low_q, data_low_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic accept, inh_done, timed, timeout, bus_idle;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk        (clk),
    .rst        (rst),
    .key_clk_i  (key_clk_i),
    .key_data_i (key_data_i),
    .clk_s_o    (clk_s),
    .data_s_o   (data_s),
    .fall_o     (fall),
    .rise_o     (clk_rise_unused)
  );

  assign accept   = tx_valid_i && (state_q == ST_IDLE);
  assign inh_done = (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1));
  assign timed    = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
  assign timeout  = timed && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign bus_idle = clk_s && data_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_INHIBIT;
      ST_INHIBIT: if (inh_done) state_d = ST_RTS;
      ST_RTS:     state_d = ST_SEND;
      ST_SEND: begin
        if (timeout)                              state_d = ST_IDLE;
        else if (fall && bitcnt_q == PS2_STOP_BIT) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (timeout)   state_d = ST_IDLE;
        else if (fall) state_d = (data_s == PS2_ACK) ? ST_WAIT_IDLE : ST_IDLE;
      end
      ST_WAIT_IDLE: if (timeout || bus_idle) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sh_d       = sh_q;
    par_d      = par_q;
    bitcnt_d   = bitcnt_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        if (accept) begin
          sh_d      = tx_data_i;
          par_d     = ~^tx_data_i;
          inh_cnt_d = '0;
          clk_low_d = 1'b1;
        end
      end
      ST_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + INH_W'(1);
        if (inh_done) data_low_d = 1'b1;
      end
      ST_RTS: begin
        // Data stays pulled low: that is the start bit.
        clk_low_d = 1'b0;
        bitcnt_d  = '0;
        to_cnt_d  = '0;
      end
      ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (timeout) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          error_d    = 1'b1;
        end else if (state_q == ST_SEND) begin
          if (fall) begin
            if (bitcnt_q < PS2_PAR_BIT)       data_low_d = ~sh_q[bitcnt_q[2:0]];
            else if (bitcnt_q == PS2_PAR_BIT) data_low_d = ~par_q;
            else                              data_low_d = 1'b0;
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else if (state_q == ST_ACK) begin
          if (fall && data_s != PS2_ACK) error_d = 1'b1;
        end else begin
          if (bus_idle) done_d = 1'b1;
        end
      end
      default: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q       <= '0;
      par_q      <= 1'b0;
      bitcnt_q   <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      par_q      <= par_d;
      bitcnt_q   <= bitcnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign tx_ready_o     = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign key_clk_low_o  = clk_low_q;
  assign key_data_low_o = data_low_q;
  assign done_o         = done_q;
  assign error_o        = error_q;

endmodule

`default_nettype wire
